// File: rtl/uart_pkg.sv
// Shared UART constants and the receive FIFO entry layout.
// An entry holds the received byte with its parity-error flag in the top bit.
package uart_pkg;

   localparam int UART_DATA_W    = 8;
   localparam int RX_FIFO_DEPTH  = 16;
   localparam int RX_FIFO_ADDR_W = 4;
   localparam int ERR_BIT        = 8;
   localparam int RX_ENTRY_W     = 9;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;
   typedef logic [RX_ENTRY_W-1:0]  rx_entry_t;

   function automatic rx_entry_t pack_entry(input logic err, input uart_byte_t data);
      return {err, data};
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_edge_detect.sv
// Two-flop synchronizer followed by a one-cycle rising-edge pulse.
// Used for strobes generated in the UART tick domain.
module sync_edge_detect (
   input  logic sysclk,
   input  logic reset,
   input  logic async_in,
   output logic pulse
);

   logic sync1_reg;
   logic sync2_reg;
   logic sync3_reg;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         sync3_reg <= 1'b0;
      end else begin
         sync1_reg <= async_in;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
      end
   end

   assign pulse = sync2_reg & ~sync3_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART core: captures each completed byte and
// its parity flag, presents the head show-ahead, and flags dropped bytes.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = RX_FIFO_DEPTH,
   parameter int ADDR_W = RX_FIFO_ADDR_W
) (
   input  logic                   sysclk,
   input  logic                   reset,
   input  logic                   rx_ready,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rx_error,
   input  logic                   rd_en,
   input  logic                   clr_ovf,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_error,
   output logic                   empty,
   output logic                   full,
   output logic [ADDR_W:0]        count,
   output logic                   overflow
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

   rx_entry_t       mem [DEPTH];
   rx_entry_t       head_entry;

   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [ADDR_W:0]   count_reg,  count_next;
   logic              overflow_reg, overflow_next;

   logic push;
   logic pop;
   logic wr_en;
   logic drop;

   sync_edge_detect u_ready_edge (
      .sysclk   (sysclk),
      .reset    (reset),
      .async_in (rx_ready),
      .pulse    (push)
   );

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign pop   = rd_en & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign drop  = push & full & ~rd_en;

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;

      if (wr_en) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_next = rd_ptr_reg + 1'b1;

      case ({wr_en, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase

      if (drop)         overflow_next = 1'b1;
      else if (clr_ovf) overflow_next = 1'b0;
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   // Storage is deliberately left out of reset; contents are masked while empty.
   always_ff @(posedge sysclk) begin
      if (wr_en) mem[wr_ptr_reg] <= pack_entry(rx_error, rx_data);
   end

   assign head_entry = mem[rd_ptr_reg];

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == FULL_COUNT);
   assign count    = count_reg;
   assign overflow = overflow_reg;
   assign rd_data  = empty ? '0 : head_entry[UART_DATA_W-1:0];
   assign rd_error = empty ? 1'b0 : head_entry[ERR_BIT];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo with a queue-based reference
// model and a monitor that compares every cycle on the falling edge.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data  = 8'h00;
   logic       rx_error = 1'b0;
   logic       rd_en    = 1'b0;
   logic       clr_ovf  = 1'b0;
   logic [7:0] rd_data;
   logic       rd_error;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;

   uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .rx_ready (rx_ready),
      .rx_data  (rx_data),
      .rx_error (rx_error),
      .rd_en    (rd_en),
      .clr_ovf  (clr_ovf),
      .rd_data  (rd_data),
      .rd_error (rd_error),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   always #5 sysclk = ~sysclk;

   // Reference state: the FIFO contents as a queue, the sticky flag, and the
   // one byte in flight between the ready edge and its write slot.
   logic [8:0] exp_q[$];
   logic       exp_ovf = 1'b0;
   logic       pend_valid = 1'b0;
   int         pend_cyc = 0;
   logic [8:0] pend_entry = '0;
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   bit         done = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // A byte becomes visible on the third rising clock after rx_ready rises.
   initial begin
      bit do_pop, do_push, set_ovf;
      forever begin
         @(posedge sysclk);
         cyc++;
         if (!reset) begin
            do_pop  = rd_en && (exp_q.size() != 0);
            do_push = pend_valid && (pend_cyc == cyc);
            if (do_push) pend_valid = 1'b0;
            set_ovf = do_push && (exp_q.size() == DEPTH) && !do_pop;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push && !set_ovf) exp_q.push_back(pend_entry);
            if (set_ovf) exp_ovf = 1'b1;
            else if (clr_ovf) exp_ovf = 1'b0;
         end
      end
   end

   // Monitor: the head of the expected queue must be what the DUT shows.
   initial begin
      forever begin
         @(negedge sysclk);
         if (done) break;
         check("empty",    int'(empty),    int'(exp_q.size() == 0));
         check("full",     int'(full),     int'(exp_q.size() == DEPTH));
         check("count",    int'(count),    exp_q.size());
         check("overflow", int'(overflow), int'(exp_ovf));
         check("rd_data",  int'(rd_data),  (exp_q.size() != 0) ? int'(exp_q[0][7:0]) : 0);
         check("rd_error", int'(rd_error), (exp_q.size() != 0) ? int'(exp_q[0][8]) : 0);
      end
   end

   task automatic apply_reset();
      @(posedge sysclk); #2;
      reset = 1'b1; rx_ready = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
      exp_q.delete(); exp_ovf = 1'b0; pend_valid = 1'b0;
      @(posedge sysclk); #2;
      reset = 1'b0;
   endtask

   // One UART frame: ready high (optionally held), rd_en optionally aligned with the write.
   task automatic send_byte(input logic [7:0] d, input logic e, input bit pop_sync, input int hold);
      @(posedge sysclk); #2;
      rx_data = d; rx_error = e; rx_ready = 1'b1;
      pend_valid = 1'b1; pend_cyc = cyc + 3; pend_entry = {e, d};
      repeat (2) @(posedge sysclk);
      #2; if (pop_sync) rd_en = 1'b1;
      @(posedge sysclk); #2;
      rd_en = 1'b0;
      repeat (hold) @(posedge sysclk);
      #2; rx_ready = 1'b0;
      repeat (2) @(posedge sysclk);
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sysclk); #2; rd_en = 1'b1;
         @(posedge sysclk); #2; rd_en = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      @(posedge sysclk); #2; clr_ovf = 1'b1;
      @(posedge sysclk); #2; clr_ovf = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge sysclk);
      #2; reset = 1'b0;
      repeat (2) @(posedge sysclk);

      // Reset mid-operation with five entries and a frame in the synchronizer.
      for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0, 1'b0, 0);
      @(posedge sysclk); #2;
      rx_data = 8'h66; rx_ready = 1'b1;
      apply_reset();
      repeat (6) @(posedge sysclk);

      // Single frame, then pop.
      send_byte(8'hA5, 1'b0, 1'b0, 0);
      pop_n(1);

      // Fill, overflow, clear, full push-with-pop, drain.
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, 1'b0, 0);
      send_byte(8'hFF, 1'b0, 1'b0, 0);
      pulse_clr();
      send_byte(8'h3C, 1'b0, 1'b1, 0);
      pop_n(DEPTH);

      // Parity flag, held ready, read on empty.
      send_byte(8'h07, 1'b1, 1'b0, 100);
      pop_n(1);
      pop_n(2);
      send_byte(8'h81, 1'b0, 1'b0, 0);
      pop_n(1);

      // Randomized traffic.
      for (int it = 0; it < 400; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 4)
            send_byte(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 3));
         else if (r <= 7) pop_n($urandom_range(1, 3));
         else if (r == 8) pulse_clr();
         else repeat ($urandom_range(1, 4)) @(posedge sysclk);
      end
      pop_n(DEPTH + 1);
      repeat (2) @(posedge sysclk);

      done = 1'b1;
      @(negedge sysclk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
